// File: rtl/aes_pkg.sv
// Shared AES constants, controller FSM encodings and the GF(2^8) xtime helper.
// Also used by the round datapath for MixColumns.
package aes_pkg;
    localparam int          AES_NR    = 10;
    localparam int          AES_BLK_W = 128;
    localparam logic [7:0]  RCON_INIT = 8'h01;
    localparam logic [7:0]  RCON_POLY = 8'h1B;

    localparam logic [2:0]  ST_IDLE  = 3'd0;
    localparam logic [2:0]  ST_ARK   = 3'd1;
    localparam logic [2:0]  ST_ISSUE = 3'd2;
    localparam logic [2:0]  ST_WAIT  = 3'd3;
    localparam logic [2:0]  ST_DONE  = 3'd4;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction
endpackage

// File: rtl/aes_round_ctrl_if.sv
// Host handshake plus round-datapath bus of the AES-128 sequencer.
// slave = controller view, master = surrounding environment view.
interface aes_round_ctrl_if;
    import aes_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [AES_BLK_W-1:0] key;
    logic [AES_BLK_W-1:0] plain_text;
    logic                 out_valid;
    logic                 out_ready;
    logic [AES_BLK_W-1:0] cipher_text;
    logic                 rnd_start;
    logic [AES_BLK_W-1:0] rnd_state;
    logic [AES_BLK_W-1:0] rnd_key;
    logic [3:0]           rnd_num;
    logic [7:0]           rnd_rcon;
    logic                 rnd_last;
    logic                 rnd_done;
    logic [AES_BLK_W-1:0] rnd_state_nxt;
    logic [AES_BLK_W-1:0] rnd_key_nxt;
    logic                 err;

    modport slave (
        input  in_valid, key, plain_text, out_ready, rnd_done, rnd_state_nxt, rnd_key_nxt,
        output in_ready, out_valid, cipher_text, rnd_start, rnd_state, rnd_key,
               rnd_num, rnd_rcon, rnd_last, err
    );

    modport master (
        output in_valid, key, plain_text, out_ready, rnd_done, rnd_state_nxt, rnd_key_nxt,
        input  in_ready, out_valid, cipher_text, rnd_start, rnd_state, rnd_key,
               rnd_num, rnd_rcon, rnd_last, err
    );
endinterface

// File: rtl/aes_rcon_gen.sv
// Round-constant register: load 01 at transaction start, xtime-advance per round.
// Output is the registered value; no handshake.
module aes_rcon_gen
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic       i_adv,
    output logic [7:0] o_rcon
);
    logic [7:0] r_rcon;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rcon <= 8'h00;
        end else if (i_load) begin
            r_rcon <= RCON_INIT;
        end else if (i_adv) begin
            r_rcon <= xtime(r_rcon);
        end
    end

    assign o_rcon = r_rcon;
endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 sequencer: initial AddRoundKey, then NR launches of an external round datapath.
// Latency 2 + NR*(1 + datapath latency); ciphertext held in DONE until out_ready.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR      = AES_NR,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    aes_round_ctrl_if.slave  bus
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [2:0]           r_fsm;
    logic [AES_BLK_W-1:0] r_state;
    logic [AES_BLK_W-1:0] r_key;
    logic [3:0]           r_cnt;
    logic [WD_W-1:0]      r_wdog;
    logic                 r_err;

    logic                 w_accept;
    logic                 w_last;
    logic                 w_timeout;
    logic                 w_rcon_adv;
    logic [7:0]           w_rcon;

    assign w_accept   = (r_fsm == ST_IDLE) && bus.in_valid;
    assign w_last     = (r_cnt == 4'(NR));
    assign w_timeout  = (r_wdog == WD_W'(TIMEOUT - 1));
    assign w_rcon_adv = (r_fsm == ST_WAIT) && bus.rnd_done && !w_last;

    aes_rcon_gen u_rcon (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_accept),
        .i_adv  (w_rcon_adv),
        .o_rcon (w_rcon)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm   <= ST_IDLE;
            r_state <= '0;
            r_key   <= '0;
            r_cnt   <= 4'd0;
            r_wdog  <= '0;
            r_err   <= 1'b0;
        end else begin
            // A completion strobe with no round outstanding is a datapath protocol error.
            if (bus.rnd_done && (r_fsm != ST_WAIT)) begin
                r_err <= 1'b1;
            end
            case (r_fsm)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= bus.plain_text ^ bus.key;
                        r_key   <= bus.key;
                        r_cnt   <= 4'd1;
                        r_fsm   <= ST_ARK;
                    end
                end
                ST_ARK: r_fsm <= ST_ISSUE;
                ST_ISSUE: begin
                    r_wdog <= '0;
                    r_fsm  <= ST_WAIT;
                end
                ST_WAIT: begin
                    // rnd_done takes priority over a watchdog expiring in the same cycle.
                    if (bus.rnd_done) begin
                        r_state <= bus.rnd_state_nxt;
                        r_key   <= bus.rnd_key_nxt;
                        if (w_last) begin
                            r_fsm <= ST_DONE;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                            r_fsm <= ST_ISSUE;
                        end
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                        r_fsm <= ST_IDLE;
                    end else begin
                        r_wdog <= r_wdog + WD_W'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_fsm <= ST_IDLE;
                    end
                end
                default: r_fsm <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready    = (r_fsm == ST_IDLE);
    assign bus.out_valid   = (r_fsm == ST_DONE);
    assign bus.cipher_text = (r_fsm == ST_DONE) ? r_state : '0;
    assign bus.rnd_start   = (r_fsm == ST_ISSUE);
    assign bus.rnd_state   = r_state;
    assign bus.rnd_key     = r_key;
    assign bus.rnd_num     = r_cnt;
    assign bus.rnd_rcon    = w_rcon;
    assign bus.rnd_last    = w_last;
    assign bus.err         = r_err;
endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Iterative AES-128 encryption sequencer. Accepts one plaintext/key pair per transaction over a valid/ready handshake.
- Performs the initial AddRoundKey itself (registered XOR). It then drives an external single-round datapath (SubBytes/ShiftRows/MixColumns/key-step) ten times, supplying round number, Rcon and a last-round flag.
- Returns the ciphertext over a valid/ready output handshake.
- Sits between the system bus wrapper and the round datapath.

Parameters:
- NR, 10, number of rounds. Fixed at 10 for AES-128; other values unsupported.
- TIMEOUT, 64, max cycles waited in WAIT for rnd_done before abort.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  plaintext/key pair presented
- in_ready  out  1  controller can accept a pair
- key  in  128  cipher key
- plain_text  in  128  plaintext block
- out_valid  out  1  ciphertext available
- out_ready  in  1  consumer accepts ciphertext
- cipher_text  out  128  result block; valid while out_valid=1
- rnd_start  out  1  one-cycle pulse launching one round
- rnd_state  out  128  state fed to round datapath
- rnd_key  out  128  current round key fed to datapath
- rnd_num  out  4  round number 1..NR
- rnd_rcon  out  8  Rcon byte for this round's key step
- rnd_last  out  1  high when rnd_num==NR (MixColumns skipped)
- rnd_done  in  1  round datapath result valid (single-cycle)
- rnd_state_nxt  in  128  round output state
- rnd_key_nxt  in  128  next round key from datapath
- err  out  1  sticky error flag

Behaviour:
- Reset (rst_n=0, async):
  - FSM=IDLE; state_reg, key_reg, cnt, rcon cleared; err=0.
  - out_valid=0, rnd_start=0, cipher_text=0, in_ready=1.
  - Reset mid-transaction abandons it; no out_valid is produced for it.
- States: IDLE, ARK, ISSUE, WAIT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: state_reg<=plain_text^key, key_reg<=key, cnt<=1, rcon<=8'h01. Go to ARK.
- ARK: one settling cycle. in_ready=0. Go to ISSUE.
- ISSUE:
  - rnd_start=1 for exactly one cycle.
  - rnd_state=state_reg, rnd_key=key_reg, rnd_num=cnt, rnd_rcon=rcon, rnd_last=(cnt==NR).
  - Go to WAIT; watchdog<=0.
- WAIT:
  - rnd_* outputs held stable.
  - On rnd_done: state_reg<=rnd_state_nxt, key_reg<=rnd_key_nxt.
    - If cnt==NR, go to DONE.
    - Else cnt<=cnt+1, rcon<=xtime(rcon), go to ISSUE.
  - xtime: {rcon[6:0],1'b0}^(rcon[7]?8'h1B:8'h00).
  - Sequence: 01,02,04,08,10,20,40,80,1B,36.
  - Watchdog increments each WAIT cycle without rnd_done. On reaching TIMEOUT: err<=1, go to IDLE, no output.
- DONE:
  - out_valid=1, cipher_text=state_reg, held stable until out_ready.
  - On out_ready: go to IDLE.
  - If in_valid is already high, it is accepted in the following IDLE cycle.
- Latency: acceptance to out_valid = 2 + Σ(1 + datapath latency) over NR rounds. With 1-cycle datapath this is 2+10×2 = 22 cycles.
- rnd_done outside WAIT: ignored for data, sets err.
- rnd_done coincident with the watchdog reaching TIMEOUT: rnd_done wins.
- err clears only on reset.
- in_valid while busy: not accepted, and the inputs are not sampled.
- key/plain_text may change after acceptance without effect.

Decomposition:
- Shared package aes_pkg:
  - AES_NR=10, AES_BLK_W=128, RCON_INIT=8'h01, RCON_POLY=8'h1B.
  - FSM state enum.
  - xtime function, reused by the MixColumns datapath.
- Natural sub-module: aes_rcon_gen (rcon register with load/advance, 8 bits).
- FSM, counter and state/key registers stay in aes_round_ctrl.

Test Plan:
- FIPS-197 C.1 with behavioural 1-cycle round model:
  - key=000102030405060708090a0b0c0d0e0f, pt=00112233445566778899aabbccddeeff.
  - rnd_state at round 1 = 00102030405060708090a0b0c0d0e0f0.
  - cipher_text=69c4e0d86a7b0430d8cdb78070b4c55a, out_valid at cycle 22.
- Rcon/round trace: check rnd_rcon per rnd_start is 01,02,04,08,10,20,40,80,1B,36; rnd_num 1..10; rnd_last only on round 10.
- Backpressure: hold out_ready=0 for 15 cycles with in_valid=1. Required: cipher_text stable, in_ready=0. Release, then the second block is accepted in the next IDLE cycle.
- Timeout: model withholds rnd_done in round 3. Required: err=1 after 64 WAIT cycles, return to IDLE, in_ready=1, no out_valid. A following vector completes correctly.
- Reset mid-run: assert rst_n=0 during round 5. Required: immediate out_valid=0, rnd_start=0, in_ready=1. A fresh C.1 vector then yields 69c4e0d8... .
- Spurious rnd_done in IDLE: err=1, state unchanged, next transaction still correct.
